// File: rtl/fetch_sequencer.sv
// Instruction fetch/sequencing stage: owns the PC, reads IMemory, hands one word at a
// time to Decode via run/ok, follows branch targets, and stops on a halt word or watchdog.
module fetch_sequencer #(
  parameter logic [18:0] RESET_PC  = 19'h0,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF,
  parameter int          TIMEOUT   = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic [16:0] IMemory_raddr,
  input  logic [31:0] IMemory_rdata,
  output logic [31:0] instr,
  output logic [18:0] PC,
  output logic        run,
  input  logic        ok,
  input  logic [31:0] PC_wdata,
  input  logic        PC_wren,
  output logic        halted,
  output logic        timeout_err,
  output logic [31:0] instr_count
);

  localparam int WDOG_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_EXEC, S_NEXT, S_HALT
  } state_t;

  state_t            state_q, state_d;
  logic [18:0]       pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  logic              halted_q, halted_d;
  logic              timeout_err_q, timeout_err_d;
  logic [31:0]       count_q, count_d;
  logic              br_pend_q, br_pend_d;
  logic [16:0]       br_tgt_q, br_tgt_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;

  // Target bits outside [18:2] are architecturally ignored.
  logic unused_wdata_bits;
  assign unused_wdata_bits = ^{PC_wdata[31:19], PC_wdata[1:0]};

  assign IMemory_raddr = pc_q[18:2];
  assign instr         = instr_q;
  assign PC            = pc_q;
  assign run           = (state_q == S_EXEC);
  assign halted        = halted_q;
  assign timeout_err   = timeout_err_q;
  assign instr_count   = count_q;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    halted_d      = halted_q;
    timeout_err_d = timeout_err_q;
    count_d       = count_q;
    br_pend_d     = br_pend_q;
    br_tgt_d      = br_tgt_q;
    wdog_d        = wdog_q;
    case (state_q)
      S_IDLE: begin
        if (enable) state_d = S_FETCH;
      end
      S_FETCH: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        instr_d = IMemory_rdata;
        if (IMemory_rdata == HALT_WORD) begin
          state_d  = S_HALT;
          halted_d = 1'b1;
        end else begin
          state_d   = S_EXEC;
          br_pend_d = 1'b0;
          wdog_d    = '0;
        end
      end
      S_EXEC: begin
        wdog_d = wdog_q + 1'b1;
        // Captured on the same edge as ok, so NEXT sees a same-cycle target too.
        if (PC_wren) begin
          br_pend_d = 1'b1;
          br_tgt_d  = PC_wdata[18:2];
        end
        if (ok) begin
          state_d = S_NEXT;
        end else if (wdog_q == WDOG_LAST) begin
          state_d       = S_HALT;
          halted_d      = 1'b1;
          timeout_err_d = 1'b1;
        end
      end
      S_NEXT: begin
        pc_d    = br_pend_q ? {br_tgt_q, 2'b00} : pc_q + 19'd4;
        count_d = count_q + 32'd1;
        state_d = enable ? S_FETCH : S_IDLE;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      halted_q      <= 1'b0;
      timeout_err_q <= 1'b0;
      count_q       <= '0;
      br_pend_q     <= 1'b0;
      wdog_q        <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      halted_q      <= halted_d;
      timeout_err_q <= timeout_err_d;
      count_q       <= count_d;
      br_pend_q     <= br_pend_d;
      wdog_q        <= wdog_d;
    end
  end

  // Branch target is only consumed when br_pend_q is set, so it needs no reset.
  always_ff @(posedge clk) begin
    br_tgt_q <= br_tgt_d;
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: program-trace reference model plus a
// Decode responder, and a second instance exercising PC wrap from RESET_PC=0x7FFFC.
module tb_fetch_sequencer;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;
  localparam int          TMO  = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, enable, ok, PC_wren;
  logic [31:0] PC_wdata, rdata;
  logic [16:0] raddr;
  logic [31:0] instr, instr_count;
  logic [18:0] PC;
  logic        run, halted, timeout_err;

  logic        rst_w, enable_w;
  logic [16:0] raddr_w;
  logic [31:0] rdata_w, instr_w, count_w;
  logic [18:0] PC_w;
  logic        run_w, halted_w, terr_w;

  logic [31:0] imem [128];
  bit          br_en [128];
  bit          br_same [128];
  bit          nook [128];
  logic [31:0] br_tgt [128];

  logic        spur_ok, spur_wren;
  logic [31:0] spur_wdata;
  int          ok_lat;
  bit          armed, gap_chk;

  int checks = 0;
  int errors = 0;

  logic [18:0] rise_pcs [$];
  logic [16:0] rise_raddr [$];

  fetch_sequencer #(.RESET_PC(19'h0), .HALT_WORD(HALT), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .IMemory_raddr(raddr), .IMemory_rdata(rdata),
    .instr(instr), .PC(PC), .run(run), .ok(ok),
    .PC_wdata(PC_wdata), .PC_wren(PC_wren),
    .halted(halted), .timeout_err(timeout_err), .instr_count(instr_count)
  );

  fetch_sequencer #(.RESET_PC(19'h7FFFC), .HALT_WORD(HALT), .TIMEOUT(TMO)) dut_w (
    .clk(clk), .rst(rst_w), .enable(enable_w),
    .IMemory_raddr(raddr_w), .IMemory_rdata(rdata_w),
    .instr(instr_w), .PC(PC_w), .run(run_w), .ok(run_w),
    .PC_wdata(32'h0), .PC_wren(1'b0),
    .halted(halted_w), .timeout_err(terr_w), .instr_count(count_w)
  );

  // Synchronous instruction memory shared by both instances
  always @(posedge clk) begin
    rdata   <= imem[raddr[6:0]];
    rdata_w <= imem[raddr_w[6:0]];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [18:0] rp(input int i);
    if (i < rise_pcs.size()) return rise_pcs[i];
    return '1;
  endfunction

  function automatic logic [16:0] ra(input int i);
    if (i < rise_raddr.size()) return rise_raddr[i];
    return '1;
  endfunction

  // Decode responder: ok after ok_lat run cycles; branch target the cycle before ok
  // (or with ok when br_same); never ok for instructions marked nook.
  initial begin : decode
    int dcnt;
    logic [6:0] didx;
    dcnt = 0;
    ok = 1'b0; PC_wren = 1'b0; PC_wdata = 32'h0;
    forever begin
      @(negedge clk);
      if (run) begin
        dcnt++;
        didx = PC[8:2];
        ok = 1'b0; PC_wren = 1'b0; PC_wdata = 32'h0;
        if (!nook[didx]) begin
          if (dcnt == ok_lat) begin
            ok = 1'b1;
            if (br_en[didx] && br_same[didx]) begin
              PC_wren = 1'b1; PC_wdata = br_tgt[didx];
            end
          end else if (dcnt == ok_lat - 1 && br_en[didx] && !br_same[didx]) begin
            PC_wren = 1'b1; PC_wdata = br_tgt[didx];
          end
        end
      end else begin
        dcnt = 0;
        ok = spur_ok; PC_wren = spur_wren; PC_wdata = spur_wdata;
      end
    end
  end

  // Reference model: the expected program trace. Each run window must present the next
  // instruction of the trace; retirement advances PC/count one cycle after run falls.
  initial begin : compare
    logic [18:0] exp_pc;
    int          exp_count, run_len, low_len;
    bit          prev_run, prev_halted, retire_pend, seen_fall;
    logic [6:0]  cidx;
    exp_pc = 19'h0; exp_count = 0; run_len = 0; low_len = 0;
    prev_run = 0; prev_halted = 0; retire_pend = 0; seen_fall = 0;
    forever begin
      @(posedge clk); #1;
      if (!armed) continue;
      if (rst) begin
        check("rst_pc", 64'(PC), 64'(19'h0));
        check("rst_run", 64'(run), 64'(0));
        check("rst_instr", 64'(instr), 64'(0));
        check("rst_count", 64'(instr_count), 64'(0));
        check("rst_halted", 64'(halted), 64'(0));
        check("rst_terr", 64'(timeout_err), 64'(0));
        exp_pc = 19'h0; exp_count = 0; run_len = 0; low_len = 0;
        prev_run = 0; prev_halted = 0; retire_pend = 0; seen_fall = 0;
        continue;
      end
      if (retire_pend) begin
        cidx = exp_pc[8:2];
        exp_pc = br_en[cidx] ? {br_tgt[cidx][18:2], 2'b00} : exp_pc + 19'd4;
        exp_count++;
        retire_pend = 0;
      end
      check("raddr_is_pc", 64'(raddr), 64'(PC[18:2]));
      check("count", 64'(instr_count), 64'(exp_count));
      if (prev_halted) check("halted_sticky", 64'(halted), 64'(1));
      if (timeout_err) check("terr_implies_halted", 64'(halted), 64'(1));
      if (run) begin
        check("run_pc", 64'(PC), 64'(exp_pc));
        check("run_instr", 64'(instr), 64'(imem[exp_pc[8:2]]));
        check("run_not_halted", 64'(halted), 64'(0));
        check("run_on_halt_word", 64'(instr == HALT), 64'(0));
        if (!prev_run) begin
          rise_pcs.push_back(PC);
          rise_raddr.push_back(raddr);
          if (seen_fall && gap_chk) check("next_fetch_wait_gap", 64'(low_len), 64'(3));
          low_len = 0;
        end
        run_len++;
      end else begin
        if (prev_run) begin
          cidx = exp_pc[8:2];
          if (nook[cidx]) begin
            check("wdog_exec_cycles", 64'(run_len), 64'(TMO));
            check("wdog_terr", 64'(timeout_err), 64'(1));
            check("wdog_halted", 64'(halted), 64'(1));
          end else begin
            check("exec_cycles", 64'(run_len), 64'(ok_lat));
            check("exec_terr", 64'(timeout_err), 64'(0));
            retire_pend = 1;
          end
          seen_fall = 1;
          run_len = 0;
          low_len = 0;
        end
        low_len++;
      end
      prev_run = run;
      prev_halted = halted;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; enable = 1'b0; spur_ok = 1'b0; spur_wren = 1'b0; spur_wdata = 32'h0;
    for (int i = 0; i < 128; i++) begin
      br_en[i] = 0; br_same[i] = 0; nook[i] = 0; br_tgt[i] = 32'h0;
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    rise_pcs.delete();
    rise_raddr.delete();
    gap_chk = 1;
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "bench did not finish");
  end

  initial begin : main
    rst = 1'b0; rst_w = 1'b0; enable = 1'b0; enable_w = 1'b0;
    spur_ok = 1'b0; spur_wren = 1'b0; spur_wdata = 32'h0;
    ok_lat = 3; gap_chk = 1; armed = 0;
    for (int i = 0; i < 128; i++) begin
      imem[i] = 32'hA500_0000 | 32'(i);
      br_en[i] = 0; br_same[i] = 0; nook[i] = 0; br_tgt[i] = 32'h0;
    end
    #1;
    rst = 1'b1; rst_w = 1'b1; armed = 1;

    // Straight-line program ending at a halt word at 0xC
    imem[3] = HALT;
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 200 && !halted; i++) @(negedge clk);
    check("t1_halted", 64'(halted), 64'(1));
    check("t1_pc", 64'(PC), 64'(19'h0000C));
    check("t1_count", 64'(instr_count), 64'(3));
    check("t1_instr", 64'(instr), 64'(HALT));
    check("t1_run", 64'(run), 64'(0));
    check("t1_terr", 64'(timeout_err), 64'(0));
    check("t1_nrises", 64'(rise_pcs.size()), 64'(3));
    check("t1_rise0", 64'(rp(0)), 64'(19'h0));
    check("t1_rise1", 64'(rp(1)), 64'(19'h4));
    check("t1_rise2", 64'(rp(2)), 64'(19'h8));

    // Jump at 0x8 to 0x40, target strobed the cycle before ok
    imem[17] = HALT;
    do_reset();
    br_en[2] = 1; br_same[2] = 0; br_tgt[2] = 32'h40;
    enable = 1'b1;
    for (int i = 0; i < 200 && !halted; i++) @(negedge clk);
    check("t2_halted", 64'(halted), 64'(1));
    check("t2_pc", 64'(PC), 64'(19'h44));
    check("t2_count", 64'(instr_count), 64'(4));
    check("t2_rise3_pc", 64'(rp(3)), 64'(19'h40));
    check("t2_rise3_raddr", 64'(ra(3)), 64'(17'h10));

    // Target and ok in the same cycle; low target bits cleared
    imem[65] = HALT;
    do_reset();
    br_en[1] = 1; br_same[1] = 1; br_tgt[1] = 32'h103;
    enable = 1'b1;
    for (int i = 0; i < 200 && !halted; i++) @(negedge clk);
    check("t3_halted", 64'(halted), 64'(1));
    check("t3_rise2_pc", 64'(rp(2)), 64'(19'h100));
    check("t3_pc", 64'(PC), 64'(19'h104));
    check("t3_count", 64'(instr_count), 64'(3));

    // Decode never answers the instruction at 0x4
    do_reset();
    nook[1] = 1;
    enable = 1'b1;
    for (int i = 0; i < 400 && !halted; i++) @(negedge clk);
    check("t4_terr", 64'(timeout_err), 64'(1));
    check("t4_halted", 64'(halted), 64'(1));
    check("t4_run", 64'(run), 64'(0));
    check("t4_count", 64'(instr_count), 64'(1));
    check("t4_pc", 64'(PC), 64'(19'h4));
    repeat (5) @(negedge clk);
    check("t4_terr_sticky", 64'(timeout_err), 64'(1));
    check("t4_run_stays_low", 64'(run), 64'(0));

    // Asynchronous reset while executing at 0x20
    do_reset();
    br_en[0] = 1; br_same[0] = 0; br_tgt[0] = 32'h20;
    enable = 1'b1;
    for (int i = 0; i < 100 && !(run && PC == 19'h20); i++) @(negedge clk);
    check("t5_reached_0x20", 64'(run && PC == 19'h20), 64'(1));
    rst = 1'b1;
    #1;
    check("t5_async_run", 64'(run), 64'(0));
    check("t5_async_pc", 64'(PC), 64'(19'h0));
    check("t5_async_count", 64'(instr_count), 64'(0));
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    rise_pcs.delete();
    for (int i = 0; i < 20 && !run; i++) @(negedge clk);
    check("t5_restart_run", 64'(run), 64'(1));
    check("t5_restart_pc", 64'(PC), 64'(19'h0));

    // enable dropped mid-instruction; spurious ok/PC_wren while idle
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 100 && !(run && PC == 19'h4); i++) @(negedge clk);
    check("t6_reached_0x4", 64'(run && PC == 19'h4), 64'(1));
    gap_chk = 0;
    enable = 1'b0;
    for (int i = 0; i < 20 && run; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("t6_idle_pc", 64'(PC), 64'(19'h8));
    check("t6_idle_count", 64'(instr_count), 64'(2));
    spur_ok = 1'b1; spur_wren = 1'b1; spur_wdata = 32'h200;
    repeat (4) @(negedge clk);
    spur_ok = 1'b0; spur_wren = 1'b0; spur_wdata = 32'h0;
    repeat (10) @(negedge clk);
    check("t6_spur_pc", 64'(PC), 64'(19'h8));
    check("t6_spur_count", 64'(instr_count), 64'(2));
    check("t6_no_new_run", 64'(rise_pcs.size()), 64'(2));
    check("t6_idle_run", 64'(run), 64'(0));
    enable = 1'b1;
    for (int i = 0; i < 20 && !run; i++) @(negedge clk);
    check("t6_resume_run", 64'(run), 64'(1));
    check("t6_resume_pc", 64'(PC), 64'(19'h8));

    // PC wrap from the top of the address space
    @(negedge clk);
    enable_w = 1'b1;
    rst_w = 1'b0;
    for (int i = 0; i < 50 && !run_w; i++) @(negedge clk);
    check("wrap_first_pc", 64'(PC_w), 64'(19'h7FFFC));
    check("wrap_first_raddr", 64'(raddr_w), 64'(17'h1FFFF));
    check("wrap_first_instr", 64'(instr_w), 64'(imem[127]));
    for (int i = 0; i < 50 && run_w; i++) @(negedge clk);
    for (int i = 0; i < 50 && !run_w; i++) @(negedge clk);
    check("wrap_second_run", 64'(run_w), 64'(1));
    check("wrap_second_pc", 64'(PC_w), 64'(19'h0));
    check("wrap_second_instr", 64'(instr_w), 64'(imem[0]));
    check("wrap_count", 64'(count_w), 64'(1));
    check("wrap_halted", 64'(halted_w), 64'(0));
    check("wrap_terr", 64'(terr_w), 64'(0));
    enable_w = 1'b0;
    repeat (5) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
